fetch_buffer_unit: RTL and testbench
====================================

FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning PC/address width.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL use one clock, with reset asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have port redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
REQ-008 SHALL have port redirect_pc  in  ADDR_W  new fetch address (branch/register target).
REQ-009 SHALL have port imem_req  out  1  instruction-memory read strobe.
REQ-010 SHALL have port imem_addr  out  ADDR_W  read address, valid when imem_req=1.
REQ-011 SHALL have port imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_req.
REQ-012 SHALL have port out_valid  out  1  queue head holds a valid instruction.
REQ-013 SHALL have port out_ready  in  1  consumer accepts head this cycle.
REQ-014 SHALL have port out_instr  out  INSTR_W  head instruction.
REQ-015 SHALL have port out_pc  out  ADDR_W  address the head instruction was fetched from.

Function
REQ-016 SHALL hold fetch_pc, a circular queue of DEPTH {pc,instr} entries, head/tail pointers, count (0..DEPTH), and a 1-bit inflight flag.
REQ-017 SHALL assert imem_req, with imem_addr=fetch_pc, when redirect_valid=0 and count+inflight < DEPTH (credit rule: never more than DEPTH entries owed).
REQ-018 SHALL advance fetch_pc by 4 (mod 2^ADDR_W, wrap-around silent) on each issued request.
REQ-019 SHALL set inflight=1 in the cycle after an issued request; the response SHALL be pushed at the tail with the request's address on that cycle's rising edge, unless squashed.
REQ-020 SHALL drive out_valid = (count != 0), with out_instr/out_pc from the head entry; no combinational bypass from imem_rdata to outputs.
REQ-021 SHALL pop the head on out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 SHALL wrap head/tail pointers modulo DEPTH.
REQ-023 On redirect_valid=1: count:=0, head:=tail, any response arriving the next cycle squashed, fetch_pc:=redirect_pc with bits[1:0] forced to 0, no request that cycle.
REQ-024 Redirect coincident with a pop SHALL still count as a consumed handshake; redirect coincident with a response arrival SHALL discard that response.
REQ-025 Back-to-back redirects SHALL each override fetch_pc; the last one wins; fetch restarts the cycle after redirect_valid deasserts.
REQ-026 Latency: redirect in cycle 0 -> imem_req for target in cycle 1 -> push at end of cycle 2 -> out_valid=1 in cycle 3.
REQ-027 Steady state with out_ready=1 SHALL sustain one instruction per cycle.
REQ-028 With out_ready=0 the queue SHALL fill to exactly DEPTH, then imem_req SHALL stay 0 until a pop frees a credit.

Reset
REQ-029 While reset=1 (asynchronously): fetch_pc=RESET_PC, count=0, head=tail=0, inflight=0, imem_req=0, out_valid=0; out_instr/out_pc SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries and any in-flight response; first request after release SHALL be imem_addr=RESET_PC on the first clock edge with reset=0.

Verification
REQ-031 Reset release, out_ready=1, imem returns addr-derived data -> out_pc sequence 0,4,8,12... from cycle 2 after release, one per cycle.
REQ-032 DEPTH=4, out_ready=0 -> exactly 4 requests (0,4,8,12), count=4, imem_req=0 thereafter; raise out_ready -> pops 0,4,8,12 then 16 issued.
REQ-033 Redirect to 0x1002 while queue holds 3 entries and a request is in flight -> out_valid=0 next cycle, in-flight data dropped, imem_addr=0x1000 next cycle, out_pc=0x1000 three cycles after redirect.
REQ-034 ADDR_W=16, redirect to 0xFFFC -> fetched out_pc sequence 0xFFFC, 0x0000, 0x0004.
REQ-035 Reset pulse asserted between clock edges while full -> out_valid and imem_req fall immediately; after release imem_addr=RESET_PC.
REQ-036 Random out_ready and redirects vs. reference model -> no lost, duplicated or reordered {pc,instr}; count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_buffer_unit.sv
// -----------------------------------------------------------------------------
// fetch_buffer_unit
//
// Purpose:
//   This is the instruction fetch front end. It issues sequential reads to
//   instruction memory and buffers the returned {pc, instr} pairs in a small
//   circular queue for the decode stage. A redirect flushes the queue and
//   restarts fetch at a new address. Memory has a fixed read latency of one
//   cycle. Issue uses credits: the queued entries plus the one in-flight read
//   never exceed DEPTH, so a returning response always has a free slot.
//
// Parameters:
//   ADDR_W   PC / address width
//   INSTR_W  instruction width
//   DEPTH    queue entries (power of two, >= 2)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   redirect_valid  flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address; bits [1:0] are ignored
//   imem_req        instruction memory read strobe
//   imem_addr       read address, valid while imem_req = 1
//   imem_rdata      read data, valid exactly one cycle after imem_req
//   out_valid       the queue head holds a valid instruction
//   out_ready       the consumer accepts the head this cycle
//   out_instr       head instruction (0 when the queue is empty)
//   out_pc          fetch address of the head instruction (0 when empty)
// -----------------------------------------------------------------------------
module fetch_buffer_unit #(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       INSTR_W  = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int unsigned      PTR_W     = $clog2(DEPTH);
   localparam int unsigned      CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   // Architectural state
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               inflight_q, inflight_d;
   // Address of the outstanding read. It is pushed together with the data.
   logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

   // Queue storage. It needs no reset, because out_* are masked while
   // count is 0.
   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];

   // Handshake / control terms
   logic [CNT_W-1:0]   owed;
   logic               has_credit;
   logic               issue;
   logic               push;
   logic               pop;
   logic [ADDR_W-1:0]  redirect_aligned;

   // -------------------------------------------------------------------------
   // Control decode
   // -------------------------------------------------------------------------
   always_comb begin
      // This sum fits CNT_W because the credit rule bounds it at DEPTH.
      owed             = count_q + CNT_W'(inflight_q);
      has_credit       = (owed < DEPTH_CNT);
      // Gating with reset keeps the strobe low while reset holds the state.
      issue            = !reset && !redirect_valid && has_credit;
      // A response that arrives in a redirect cycle belongs to the old
      // stream, so it is dropped.
      push             = inflight_q && !redirect_valid;
      pop              = out_valid && out_ready;
      redirect_aligned = redirect_pc & ~ADDR_W'(3);
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;

      if (issue) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      end

      if (redirect_valid) begin
         // A pop in this cycle still completes on the consumer side. The
         // flush simply drops every entry that was behind it.
         count_d    = '0;
         head_d     = tail_q;
         fetch_pc_d = redirect_aligned;
      end else begin
         // DEPTH is a power of two, so the pointers wrap on their own.
         if (pop)  head_d = head_q + PTR_W'(1);
         if (push) tail_d = tail_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Queue write port. It cannot overflow, because the credit rule
   // reserved this slot at issue time.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[tail_q]    <= inflight_pc_q;
         instr_mem_q[tail_q] <= imem_rdata;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      imem_req  = issue;
      imem_addr = fetch_pc_q;
      out_valid = (count_q != '0);
      out_instr = out_valid ? instr_mem_q[head_q] : '0;
      out_pc    = out_valid ? pc_mem_q[head_q]    : '0;
   end

   // The credit rule must keep occupancy plus the outstanding read within
   // DEPTH.
   a_owed_bounded : assert property (@(posedge clk) disable iff (reset)
      (count_q + CNT_W'(inflight_q)) <= DEPTH_CNT);

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer_unit
//   This bench checks fetch_buffer_unit with directed vectors. It drives two
//   instances: the default 64-bit instance and a 16-bit instance used for
//   the address wrap case. Instruction memory returns addr[31:0] ^
//   32'hDEADBEEF one cycle after each request.
// -----------------------------------------------------------------------------
module tb_fetch_buffer_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 64-bit DUT
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   // 16-bit DUT
   logic        reset16;
   logic        redirect_valid16;
   logic [15:0] redirect_pc16;
   logic        imem_req16;
   logic [15:0] imem_addr16;
   logic [31:0] imem_rdata16;
   logic        out_valid16;
   logic        out_ready16;
   logic [31:0] out_instr16;
   logic [15:0] out_pc16;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_buffer_unit #(
      .ADDR_W   (64),
      .INSTR_W  (32),
      .DEPTH    (4),
      .RESET_PC (64'h0)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   fetch_buffer_unit #(
      .ADDR_W   (16),
      .INSTR_W  (32),
      .DEPTH    (4),
      .RESET_PC (16'h0)
   ) u_dut16 (
      .clk            (clk),
      .reset          (reset16),
      .redirect_valid (redirect_valid16),
      .redirect_pc    (redirect_pc16),
      .imem_req       (imem_req16),
      .imem_addr      (imem_addr16),
      .imem_rdata     (imem_rdata16),
      .out_valid      (out_valid16),
      .out_ready      (out_ready16),
      .out_instr      (out_instr16),
      .out_pc         (out_pc16)
   );

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ 32'hDEAD_BEEF;
   endfunction

   // Instruction memory model with a one-cycle read latency
   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= instr_of(imem_addr);
      if (imem_req16) imem_rdata16 <= instr_of({48'h0, imem_addr16});
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   logic [63:0] exp_pc;
   logic [63:0] tgt;
   int          nreq;
   int          npop;
   logic        redir;

   initial begin
      reset            = 1'b1;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      out_ready        = 1'b0;
      reset16          = 1'b1;
      redirect_valid16 = 1'b0;
      redirect_pc16    = '0;
      out_ready16      = 1'b0;
      imem_rdata       = '0;
      imem_rdata16     = '0;

      // ---- Reset state ----
      tick();
      tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_imem_req",  64'(imem_req),  64'd0);
      check_eq("rst_out_pc",    out_pc,         64'd0);
      check_eq("rst_out_instr", 64'(out_instr), 64'd0);

      // ---- Streaming after release, out_ready = 1 ----
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      check_eq("rel_req",  64'(imem_req), 64'd1);
      check_eq("rel_addr", imem_addr,     64'd0);
      tick();
      check_eq("c1_valid", 64'(out_valid), 64'd0);
      check_eq("c1_addr",  imem_addr,      64'd4);
      tick();
      check_eq("c2_valid", 64'(out_valid), 64'd1);
      check_eq("c2_pc",    out_pc,         64'd0);
      check_eq("c2_instr", 64'(out_instr), 64'(instr_of(64'd0)));
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_eq("stream_valid", 64'(out_valid), 64'd1);
         check_eq("stream_pc",    out_pc,         64'(4 * k));
      end

      // ---- Fill to DEPTH with out_ready = 0 ----
      out_ready = 1'b0;
      do_reset();
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req) begin
            check_eq("fill_addr", imem_addr, 64'(4 * nreq));
            nreq++;
         end
         tick();
      end
      check_eq("fill_nreq",  64'(nreq),           64'd4);
      check_eq("fill_count", 64'(u_dut.count_q),  64'd4);
      check_eq("fill_req",   64'(imem_req),       64'd0);
      check_eq("fill_pc",    out_pc,              64'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_eq("drain_valid", 64'(out_valid), 64'd1);
         check_eq("drain_pc",    out_pc,         64'(4 * k));
         if (k == 0) check_eq("drain_req0", 64'(imem_req), 64'd0);
         if (k == 1) begin
            check_eq("drain_req1",  64'(imem_req), 64'd1);
            check_eq("drain_addr1", imem_addr,     64'd16);
         end
         tick();
      end

      // ---- Redirect with 3 entries queued and one read in flight ----
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      check_eq("pre_redir_count", 64'(u_dut.count_q),    64'd3);
      check_eq("pre_redir_infl",  64'(u_dut.inflight_q), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h1002;
      #1;
      check_eq("redir_req", 64'(imem_req), 64'd0);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      #1;
      check_eq("redir1_valid", 64'(out_valid), 64'd0);
      check_eq("redir1_req",   64'(imem_req),  64'd1);
      check_eq("redir1_addr",  imem_addr,      64'h1000);
      tick();
      check_eq("redir2_valid", 64'(out_valid), 64'd0);
      tick();
      check_eq("redir3_valid", 64'(out_valid), 64'd1);
      check_eq("redir3_pc",    out_pc,         64'h1000);
      check_eq("redir3_instr", 64'(out_instr), 64'(instr_of(64'h1000)));
      tick();
      check_eq("redir4_pc",    out_pc,         64'h1004);

      // ---- Back-to-back redirects: the last one wins ----
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2000;
      tick();
      redirect_pc    = 64'h3001;
      #1;
      check_eq("b2b_req", 64'(imem_req), 64'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("b2b_addr",  imem_addr,      64'h3000);
      check_eq("b2b_valid", 64'(out_valid), 64'd0);
      tick();
      tick();
      check_eq("b2b_pc", out_pc, 64'h3000);

      // ---- Asynchronous reset while full ----
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check_eq("full_valid", 64'(out_valid), 64'd1);
      check_eq("full_req",   64'(imem_req),  64'd0);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_valid", 64'(out_valid), 64'd0);
      check_eq("arst_req",   64'(imem_req),  64'd0);
      check_eq("arst_pc",    out_pc,         64'd0);
      tick();
      reset = 1'b0;
      #1;
      check_eq("arst_rel_req",  64'(imem_req), 64'd1);
      check_eq("arst_rel_addr", imem_addr,     64'd0);
      out_ready = 1'b1;
      tick();
      tick();
      check_eq("arst_first_pc", out_pc, 64'd0);

      // ---- 16-bit address wrap ----
      reset16          = 1'b0;
      redirect_valid16 = 1'b1;
      redirect_pc16    = 16'hFFFC;
      out_ready16      = 1'b1;
      #1;
      check_eq("w16_redir_req", 64'(imem_req16), 64'd0);
      tick();
      redirect_valid16 = 1'b0;
      #1;
      check_eq("w16_addr", 64'(imem_addr16), 64'hFFFC);
      tick();
      tick();
      check_eq("w16_pc0",    64'(out_pc16),    64'hFFFC);
      check_eq("w16_instr0", 64'(out_instr16), 64'(instr_of(64'hFFFC)));
      tick();
      check_eq("w16_pc1",    64'(out_pc16),    64'h0000);
      tick();
      check_eq("w16_pc2",    64'(out_pc16),    64'h0004);

      // ---- Random out_ready / redirects against the stream model ----
      do_reset();
      exp_pc = 64'd0;
      npop   = 0;
      for (int i = 0; i < 300; i++) begin
         out_ready      = 1'($urandom_range(0, 1));
         redir          = ($urandom_range(0, 15) == 0);
         tgt            = {$urandom(), $urandom()};
         redirect_valid = redir;
         redirect_pc    = tgt;
         #1;
         if (out_valid && out_ready) begin
            check_eq("rnd_pc",    out_pc,         exp_pc);
            check_eq("rnd_instr", 64'(out_instr), 64'(instr_of(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            npop++;
         end
         if (redir) exp_pc = tgt & ~64'd3;
         check_eq("rnd_count_le_depth", 64'(u_dut.count_q <= 3'd4), 64'd1);
         tick();
      end
      redirect_valid = 1'b0;
      check_eq("rnd_progress", 64'(npop > 50), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
